// File: rtl/tick_sched_pkg.sv
// Shared types and constants for the tick scheduler: FSM states, channel
// selects and default periods.
package tick_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        STEP  = 2'd3
    } state_t;

    localparam logic [1:0] CH_GAME  = 2'd0;
    localparam logic [1:0] CH_BLINK = 2'd1;
    localparam logic [1:0] CH_FAST  = 2'd2;

    localparam int unsigned DEF_GAME_PERIOD  = 2000000;
    localparam int unsigned DEF_BLINK_PERIOD = 66000000;
    localparam int unsigned DEF_FAST_PERIOD  = 200000;
    localparam int unsigned MIN_PERIOD       = 2;

endpackage

// File: rtl/tick_chan.sv
// One strobe channel: wrap counter with live and shadow period. The shadow
// is applied at the next wrap, or right away while imm is high.
module tick_chan
    import tick_sched_pkg::*;
#(
    parameter int          CNT_W      = 28,
    parameter int unsigned DEF_PERIOD = DEF_FAST_PERIOD
) (
    input  logic             clock_in,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic             load,
    input  logic             imm,
    input  logic [CNT_W-1:0] wdata,
    output logic             tick,
    output logic             pending
);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] shadow;
    logic [CNT_W-1:0] wval;

    assign wval = (wdata < CNT_W'(MIN_PERIOD)) ? CNT_W'(MIN_PERIOD) : wdata;
    // >= rather than == so a period shrunk below a held count still wraps
    assign tick = en && (cnt >= period - CNT_W'(1));

    always_ff @(posedge clock_in or negedge rst) begin
        if (!rst) begin
            cnt     <= '0;
            period  <= CNT_W'(DEF_PERIOD);
            shadow  <= '0;
            pending <= 1'b0;
        end else begin
            if (clr || tick)
                cnt <= '0;
            else if (en)
                cnt <= cnt + CNT_W'(1);

            if (load && imm) begin
                period  <= wval;
                pending <= 1'b0;
            end else if (load) begin
                shadow  <= wval;
                pending <= 1'b1;
            end else if (pending && (tick || imm)) begin
                period  <= shadow;
                pending <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/tick_scheduler.sv
// Tick scheduler top: run/pause/step FSM, period config handshake, overrun
// tracking and blink level. Optional macro TICK_OVERRUN_CNT_EN adds overrun_cnt.
module tick_scheduler
    import tick_sched_pkg::*;
#(
    parameter int          CNT_W        = 28,
    parameter int unsigned GAME_PERIOD  = DEF_GAME_PERIOD,
    parameter int unsigned BLINK_PERIOD = DEF_BLINK_PERIOD,
    parameter int unsigned FAST_PERIOD  = DEF_FAST_PERIOD
) (
    input  logic             clock_in,
    input  logic             rst,
    input  logic             start,
    input  logic             pause,
    input  logic             step,
    input  logic             game_busy,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [1:0]       cfg_sel,
    input  logic [CNT_W-1:0] cfg_period,
    output logic             tick_game,
    output logic             tick_blink,
    output logic             tick_fast,
    output logic             blink_lvl,
    output logic [1:0]       state_o,
    output logic             overrun
`ifdef TICK_OVERRUN_CNT_EN
    ,
    output logic [7:0]       overrun_cnt
`endif
);

    state_t     state;
    logic [2:0] pend;
    logic       accept;
    logic       game_en, game_clr, game_imm;
    logic       game_wrap, blink_wrap, fast_wrap;
    logic       step_go, game_fire;

    assign cfg_ready = ~|pend;
    assign accept    = cfg_valid && cfg_ready;
    assign state_o   = state;

    // pause is sampled directly so the count freezes on the cycle it is seen
    assign game_en   = (state == RUN) && !pause;
    assign game_clr  = (state == IDLE) && start;
    assign game_imm  = (state == IDLE) || (state == PAUSE);
    assign step_go   = (state == PAUSE) && pause && step;
    assign game_fire = game_wrap || step_go;

    tick_chan #(.CNT_W(CNT_W), .DEF_PERIOD(GAME_PERIOD)) u_game (
        .clock_in (clock_in),
        .rst      (rst),
        .en       (game_en),
        .clr      (game_clr),
        .load     (accept && (cfg_sel == CH_GAME)),
        .imm      (game_imm),
        .wdata    (cfg_period),
        .tick     (game_wrap),
        .pending  (pend[0])
    );

    tick_chan #(.CNT_W(CNT_W), .DEF_PERIOD(BLINK_PERIOD)) u_blink (
        .clock_in (clock_in),
        .rst      (rst),
        .en       (1'b1),
        .clr      (1'b0),
        .load     (accept && (cfg_sel == CH_BLINK)),
        .imm      (1'b0),
        .wdata    (cfg_period),
        .tick     (blink_wrap),
        .pending  (pend[1])
    );

    tick_chan #(.CNT_W(CNT_W), .DEF_PERIOD(FAST_PERIOD)) u_fast (
        .clock_in (clock_in),
        .rst      (rst),
        .en       (1'b1),
        .clr      (1'b0),
        .load     (accept && (cfg_sel == CH_FAST)),
        .imm      (1'b0),
        .wdata    (cfg_period),
        .tick     (fast_wrap),
        .pending  (pend[2])
    );

    always_ff @(posedge clock_in or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            tick_game <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            tick_game <= game_fire && !game_busy;
            if (game_fire && game_busy)
                overrun <= 1'b1;
            else if (game_clr)
                overrun <= 1'b0;

            case (state)
                IDLE:    if (start) state <= RUN;
                RUN:     if (pause) state <= PAUSE;
                PAUSE:   if (!pause) state <= RUN;
                         else if (step) state <= STEP;
                default: state <= PAUSE;
            endcase
        end
    end

    always_ff @(posedge clock_in or negedge rst) begin
        if (!rst) begin
            tick_blink <= 1'b0;
            tick_fast  <= 1'b0;
            blink_lvl  <= 1'b0;
        end else begin
            tick_blink <= blink_wrap;
            tick_fast  <= fast_wrap;
            if (blink_wrap)
                blink_lvl <= ~blink_lvl;
        end
    end

`ifdef TICK_OVERRUN_CNT_EN
    always_ff @(posedge clock_in or negedge rst) begin
        if (!rst)
            overrun_cnt <= '0;
        else if (game_clr)
            overrun_cnt <= '0;
        else if (game_fire && game_busy && (overrun_cnt != 8'hFF))
            overrun_cnt <= overrun_cnt + 8'd1;
    end
`endif

endmodule
